pipe_hold_ctrl: RTL and testbench
=================================

PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, number of consecutive Hold_Id cycles issued per taken jump; legal range 1..3.
REQ-002 Parameter: LU_CYCLES, 1, number of Hold_If cycles issued per load-use hazard; legal range 1..3.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low.
REQ-005 Port: jump_flag_i  input  1  taken jump/branch/trap from EX.
REQ-006 Port: jump_addr_i  input  32  jump target, valid with jump_flag_i.
REQ-007 Port: hold_flag_ex_i  input  1  EX multi-cycle operation busy (e.g. divider).
REQ-008 Port: hold_flag_rib_i  input  1  bus arbiter requests a PC freeze.
REQ-009 Port: ex_mem_rd_i  input  1  instruction now in EX is a load.
REQ-010 Port: ex_rd_i  input  5  EX destination register.
REQ-011 Port: id_rs1_i, id_rs2_i  input  5 each  ID source registers.
REQ-012 Port: hold_flag_o  output  3  pipeline hold level: 000 none, 001 Hold_Pc, 010 Hold_If, 011 Hold_Id.
REQ-013 Port: hold_time_o  output  3  3'b111 one-cycle marker for a flush start, else 000.
REQ-014 Port: jump_flag_o  output  1  one-cycle redirect strobe to PC.
REQ-015 Port: jump_addr_o  output  32  redirect target.
REQ-016 Port: stall_cnt_o  output  16  saturating count of cycles with hold_flag_o != 000.

Function
REQ-017 All outputs SHALL be registered; response appears 1 cycle after the sampled request.
REQ-018 FSM states SHALL be IDLE, FLUSH, EX_WAIT, BUS_WAIT, LU_STALL, with a 2-bit cycle counter cnt.
REQ-019 Request priority SHALL be jump > hold_flag_ex_i > hold_flag_rib_i > load-use, evaluated each cycle in every state.
REQ-020 Load-use SHALL be detected as ex_mem_rd_i && ex_rd_i != 0 && (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i).
REQ-021 On jump_flag_i in any state: go to FLUSH, cnt = FLUSH_CYCLES-1, output hold_flag_o = 011, hold_time_o = 111, jump_flag_o = 1, jump_addr_o = jump_addr_i.
REQ-022 In FLUSH with no new jump: hold_flag_o = 011, hold_time_o = 000, jump_flag_o = 0; decrement cnt; leave to IDLE (or a pending lower request) after cnt reaches 0.
REQ-023 A jump arriving during FLUSH SHALL restart the flush with the new target (counter reloaded, jump_flag_o pulsed again).
REQ-024 EX_WAIT: hold_flag_o = 011 each cycle hold_flag_ex_i is sampled high; return to IDLE (hold_flag_o = 000) the cycle after it drops.
REQ-025 BUS_WAIT: hold_flag_o = 001 while hold_flag_rib_i is sampled high; same release rule as REQ-024.
REQ-026 LU_STALL: hold_flag_o = 010 for exactly LU_CYCLES cycles, then IDLE; a still-present hazard re-triggers.
REQ-027 IDLE with no request: hold_flag_o = 000, hold_time_o = 000, jump_flag_o = 0; jump_addr_o holds its last value.
REQ-028 stall_cnt_o SHALL increment when the registered hold_flag_o is non-zero and saturate at 16'hFFFF.
REQ-029 Simultaneous jump and any other request: jump wins; lower request is re-evaluated after flush ends.

Reset
REQ-030 While rst = 0: state IDLE, cnt 0, hold_flag_o 000, hold_time_o 000, jump_flag_o 0, jump_addr_o 0, stall_cnt_o 0, asynchronously.
REQ-031 Reset asserted mid-FLUSH or mid-stall SHALL abort immediately; after release the block starts in IDLE with no residual hold.

Verification
REQ-032 Jump pulse, target 32'h0000_0100, defaults -> next cycle jump_flag_o = 1, addr 0x100, hold 011, hold_time 111; following cycle hold 011, time 000; then 000; stall_cnt_o = 2.
REQ-033 ex_mem_rd_i = 1, ex_rd_i = 5, id_rs2_i = 5 for 1 cycle -> hold_flag_o = 010 for 1 cycle; ex_rd_i = 0 same case -> no stall.
REQ-034 hold_flag_ex_i high 4 cycles with hold_flag_rib_i high -> hold 011 for 4 cycles, then 001 while rib remains high.
REQ-035 Jump during second flush cycle with target 0x200 -> jump_flag_o re-pulses, addr 0x200, flush length restarts (2 cycles).
REQ-036 rst low during EX_WAIT -> all outputs 0 without waiting for clk edge; after release with no requests, hold_flag_o stays 000.
REQ-037 Force 65536 stalled cycles -> stall_cnt_o holds 16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_hold_ctrl
// Central pipeline hold / redirect controller. Each cycle it picks the most
// urgent request, from highest to lowest:
//   1. taken jump
//   2. EX busy
//   3. bus freeze
//   4. load-use hazard
// It then drives a registered hold level, a flush marker and a PC redirect one
// cycle later. It also keeps a saturating count of cycles spent holding.
//
// Parameters
//   FLUSH_CYCLES  Hold_Id cycles issued per taken jump (1..3)
//   LU_CYCLES     Hold_If cycles issued per load-use hazard (1..3)
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   jump_flag_i      taken jump/branch/trap from EX
//   jump_addr_i      jump target, valid with jump_flag_i
//   hold_flag_ex_i   EX multi-cycle operation busy
//   hold_flag_rib_i  bus arbiter requests a PC freeze
//   ex_mem_rd_i      instruction in EX is a load
//   ex_rd_i          EX destination register
//   id_rs1_i         ID source register 1
//   id_rs2_i         ID source register 2
//   hold_flag_o      hold level: 000 none, 001 Hold_Pc, 010 Hold_If, 011 Hold_Id
//   hold_time_o      3'b111 on the first cycle of a flush, else 000
//   jump_flag_o      one-cycle redirect strobe to PC
//   jump_addr_o      redirect target (keeps its last value)
//   stall_cnt_o      saturating count of cycles with hold_flag_o != 000
// -----------------------------------------------------------------------------
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int LU_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_rib_i,
  input  logic        ex_mem_rd_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  output logic [2:0]  hold_flag_o,
  output logic [2:0]  hold_time_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_EX_WAIT  = 3'd2,
    ST_BUS_WAIT = 3'd3,
    ST_LU_STALL = 3'd4
  } state_t;

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  // Counter reload values: cnt counts the cycles still owed after the current one.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] LU_LOAD    = 2'(LU_CYCLES - 1);

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic [2:0]  hold_flag_r;
  logic [2:0]  hold_time_r;
  logic        jump_flag_r;
  logic [31:0] jump_addr_r;
  logic [15:0] stall_cnt_r;

  logic        lu_hazard_s;
  logic        flush_busy_s;
  logic        lu_busy_s;

  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign lu_hazard_s  = ex_mem_rd_i && (ex_rd_i != 5'd0) &&
                        ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  // A flush or load-use stall still owes cycles only while its counter is non-zero.
  assign flush_busy_s = (state_r == ST_FLUSH)    && (cnt_r != 2'd0);
  assign lu_busy_s    = (state_r == ST_LU_STALL) && (cnt_r != 2'd0);

  // Hold FSM: priority arbitration and registered hold/redirect outputs.
  // An unfinished flush outranks EX/bus/load-use, so lower requests wait for it.
  // An unfinished load-use stall ranks below EX and bus, which cancel it.
  // Any illegal state code falls through to the same chain and recovers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      hold_flag_r <= HOLD_NONE;
      hold_time_r <= 3'b000;
      jump_flag_r <= 1'b0;
      jump_addr_r <= 32'd0;
    end else begin
      hold_time_r <= 3'b000;
      jump_flag_r <= 1'b0;
      if (jump_flag_i) begin
        state_r     <= ST_FLUSH;
        cnt_r       <= FLUSH_LOAD;
        hold_flag_r <= HOLD_ID;
        hold_time_r <= 3'b111;
        jump_flag_r <= 1'b1;
        jump_addr_r <= jump_addr_i;
      end else if (flush_busy_s) begin
        state_r     <= ST_FLUSH;
        cnt_r       <= cnt_r - 2'd1;
        hold_flag_r <= HOLD_ID;
      end else if (hold_flag_ex_i) begin
        state_r     <= ST_EX_WAIT;
        cnt_r       <= 2'd0;
        hold_flag_r <= HOLD_ID;
      end else if (hold_flag_rib_i) begin
        state_r     <= ST_BUS_WAIT;
        cnt_r       <= 2'd0;
        hold_flag_r <= HOLD_PC;
      end else if (lu_busy_s) begin
        state_r     <= ST_LU_STALL;
        cnt_r       <= cnt_r - 2'd1;
        hold_flag_r <= HOLD_IF;
      end else if (lu_hazard_s) begin
        state_r     <= ST_LU_STALL;
        cnt_r       <= LU_LOAD;
        hold_flag_r <= HOLD_IF;
      end else begin
        state_r     <= ST_IDLE;
        cnt_r       <= 2'd0;
        hold_flag_r <= HOLD_NONE;
      end
    end
  end

  // Stall counter: counts cycles where the registered hold level is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if ((hold_flag_r != HOLD_NONE) && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hold_flag_o = hold_flag_r;
  assign hold_time_o = hold_time_r;
  assign jump_flag_o = jump_flag_r;
  assign jump_addr_o = jump_addr_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
`timescale 1ns/1ps
// Testbench for pipe_hold_ctrl: two instances (default and FLUSH=3/LU=2)
// share one randomized + directed stimulus stream; a reference model
// predicts each cycle's outputs into per-instance queues that a separate
// monitor drains and compares.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        hold_flag_ex_i = 1'b0;
  logic        hold_flag_rib_i = 1'b0;
  logic        ex_mem_rd_i = 1'b0;
  logic [4:0]  ex_rd_i = 5'd0;
  logic [4:0]  id_rs1_i = 5'd0;
  logic [4:0]  id_rs2_i = 5'd0;

  logic [2:0]  h0, t0, h1, t1;
  logic        j0, j1;
  logic [31:0] a0, a1;
  logic [15:0] s0, s1;

  always #5 clk = ~clk;

  pipe_hold_ctrl u_dut0 (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .hold_flag_o(h0), .hold_time_o(t0), .jump_flag_o(j0),
    .jump_addr_o(a0), .stall_cnt_o(s0)
  );

  pipe_hold_ctrl #(.FLUSH_CYCLES(3), .LU_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .hold_flag_o(h1), .hold_time_o(t1), .jump_flag_o(j1),
    .jump_addr_o(a1), .stall_cnt_o(s1)
  );

  typedef struct packed {
    logic        jf;
    logic [31:0] ja;
    logic        hex;
    logic        hrib;
    logic        memrd;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stim_t;

  typedef struct packed {
    logic [2:0]  hold;
    logic [2:0]  htime;
    logic        jf;
    logic [31:0] addr;
    logic [15:0] stall;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state, index 0 = default instance, 1 = FLUSH 3 / LU 2.
  int          m_fc[2] = '{2, 3};
  int          m_lc[2] = '{1, 2};
  int          m_flush[2];
  int          m_lu[2];
  int          m_stall[2];
  bit          m_prev_nz[2];
  logic [31:0] m_addr[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_flush[i] = 0;
      m_lu[i] = 0;
      m_stall[i] = 0;
      m_prev_nz[i] = 1'b0;
      m_addr[i] = 32'd0;
    end
  endtask

  // Owed-cycle bookkeeping straight from the priority rules.
  task automatic model_step(input int i, input stim_t s, output exp_t e);
    bit hazard;
    hazard = s.memrd && (s.rd != 5'd0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
    e.htime = 3'd0;
    e.jf = 1'b0;
    if (s.jf) begin
      e.hold = 3'd3; e.htime = 3'd7; e.jf = 1'b1;
      m_addr[i] = s.ja; m_flush[i] = m_fc[i] - 1; m_lu[i] = 0;
    end else if (m_flush[i] > 0) begin
      e.hold = 3'd3; m_flush[i]--;
    end else if (s.hex) begin
      e.hold = 3'd3; m_lu[i] = 0;
    end else if (s.hrib) begin
      e.hold = 3'd1; m_lu[i] = 0;
    end else if (m_lu[i] > 0) begin
      e.hold = 3'd2; m_lu[i]--;
    end else if (hazard) begin
      e.hold = 3'd2; m_lu[i] = m_lc[i] - 1;
    end else begin
      e.hold = 3'd0;
    end
    e.addr = m_addr[i];
    if (m_prev_nz[i] && (m_stall[i] < 65535)) m_stall[i]++;
    e.stall = 16'(m_stall[i]);
    m_prev_nz[i] = (e.hold != 3'd0);
  endtask

  function automatic stim_t mk(input logic jf, input logic [31:0] ja, input logic hex,
                               input logic hrib, input logic memrd, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s;
    s.jf = jf; s.ja = ja; s.hex = hex; s.hrib = hrib;
    s.memrd = memrd; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.jf    = ($urandom_range(0, 9) == 0);
    s.ja    = $urandom;
    s.hex   = ($urandom_range(0, 5) == 0);
    s.hrib  = ($urandom_range(0, 5) == 0);
    s.memrd = ($urandom_range(0, 1) == 0);
    s.rd    = 5'($urandom_range(0, 3));
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    return s;
  endfunction

  // Called at a negedge: apply inputs, queue predictions, advance one cycle.
  task automatic tick(input stim_t s);
    exp_t e0, e1;
    jump_flag_i = s.jf; jump_addr_i = s.ja;
    hold_flag_ex_i = s.hex; hold_flag_rib_i = s.hrib;
    ex_mem_rd_i = s.memrd; ex_rd_i = s.rd; id_rs1_i = s.rs1; id_rs2_i = s.rs2;
    model_step(0, s, e0);
    model_step(1, s, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(negedge clk);
  endtask

  // Called at a negedge: async reset with immediate output check, then release.
  task automatic do_reset();
    stim_t s;
    q0.delete();
    q1.delete();
    rst = 1'b0;
    #1;
    chk("reset_outs0", {h0, t0, j0, a0, s0}, 64'd0);
    chk("reset_outs1", {h1, t1, j1, a1, s1}, 64'd0);
    repeat (2) begin
      s = rnd();
      jump_flag_i = s.jf; hold_flag_ex_i = s.hex; hold_flag_rib_i = s.hrib;
      @(negedge clk);
    end
    chk("reset_held0", {h0, t0, j0, a0, s0}, 64'd0);
    model_reset();
    rst = 1'b1;
  endtask

  // Monitor: outputs are registered, so compare shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("sb_dut0", 64'({h0, t0, j0, a0, s0}), 64'(e));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("sb_dut1", 64'({h1, t1, j1, a1, s1}), 64'(e));
      end
    end
  end

  initial begin
    stim_t idle_s;
    idle_s = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    model_reset();
    #2;
    chk("por_outs", {h0, t0, j0, a0, s0}, 64'd0);
    @(negedge clk);
    do_reset();

    // Single jump to 0x100.
    tick(mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    chk("jmp_strobe", {j0, a0, h0, t0}, {1'b1, 32'h100, 3'b011, 3'b111});
    tick(idle_s);
    chk("jmp_flush2", {j0, h0, t0}, {1'b0, 3'b011, 3'b000});
    tick(idle_s);
    chk("jmp_done", {h0, t0}, {3'b000, 3'b000});
    chk("jmp_stall", s0, 16'd2);

    // Load-use hazard, and the x0 exemption.
    tick(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5));
    chk("lu_hold", h0, 3'b010);
    tick(idle_s);
    chk("lu_release", h0, 3'b000);
    tick(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0));
    chk("lu_x0", h0, 3'b000);

    // EX busy outranks bus freeze.
    repeat (4) begin
      tick(mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0));
      chk("ex_over_rib", h0, 3'b011);
    end
    repeat (3) begin
      tick(mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0));
      chk("rib_hold", h0, 3'b001);
    end
    tick(idle_s);
    chk("rib_release", h0, 3'b000);

    // Jump arriving mid-flush restarts it.
    tick(mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    tick(idle_s);
    chk("reflush_mid", {j0, h0}, {1'b0, 3'b011});
    tick(mk(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    chk("reflush_strobe", {j0, a0, h0, t0}, {1'b1, 32'h200, 3'b011, 3'b111});
    tick(idle_s);
    chk("reflush_2", {j0, h0, t0}, {1'b0, 3'b011, 3'b000});
    tick(idle_s);
    chk("reflush_done", {h0, a0}, {3'b000, 32'h200});

    // Reset during EX_WAIT aborts; no residual hold afterwards.
    repeat (3) tick(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    chk("exwait_pre", h0, 3'b011);
    do_reset();
    repeat (3) begin
      tick(idle_s);
      chk("post_reset_idle", h0, 3'b000);
    end

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) tick(rnd());

    // Stall counter saturation.
    do_reset();
    repeat (65540) tick(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    chk("stall_sat", s0, 16'hFFFF);
    tick(idle_s);
    chk("stall_nowrap", s0, 16'hFFFF);
    tick(idle_s);
    chk("stall_nowrap2", {h0, s0}, {3'b000, 16'hFFFF});

    @(posedge clk);
    #3;
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
